// File: rtl/cla_add_sequencer.sv
// Purpose: shares one 8-bit CLA slice among NUM_REQ requesters to perform WIDTH-bit adds, one byte per cycle.
// Latency: BEATS+1 cycles from accept to rsp_valid; one operation in flight, so peak rate is one op per BEATS+2 cycles.
// Backpressure: rsp_valid/id/sum/cout hold until rsp_ready; no request is accepted until the response is taken.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   req_valid/req_ready         per-requester handshake; req_ready is one-hot (or zero), combinational, IDLE only
//   req_a/req_b                 packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin                     per-requester carry-in
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/rsp_sum/rsp_cout     owner id, (A+B+cin) mod 2^WIDTH, carry out of bit WIDTH-1

// 8-bit carry-lookahead adder slice: {cout,sum} = add1 + add2 + cin.
// Two 4-bit lookahead groups; the low group's carry-out feeds the high group.
module add_8_1 (
  input  logic [7:0] add1,
  input  logic [7:0] add2,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [3:0] c_lo;
  logic [3:0] c_hi;
  logic [7:0] c_in_bit;

  // Carries c1..c4 of a 4-bit group, each a flat sum of generate/propagate products.
  function automatic logic [3:0] cla4(input logic [3:0] gg, input logic [3:0] pp, input logic ci);
    logic [3:0] c;
    c[0] = gg[0] | (pp[0] & ci);
    c[1] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
    c[2] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & ci);
    c[3] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
         | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
    return c;
  endfunction

  assign g        = add1 & add2;
  assign p        = add1 ^ add2;
  assign c_lo     = cla4(g[3:0], p[3:0], cin);
  assign c_hi     = cla4(g[7:4], p[7:4], c_lo[3]);
  assign c_in_bit = {c_hi[2:0], c_lo, cin};
  assign sum      = p ^ c_in_bit;
  assign cout     = c_hi[3];

endmodule

module cla_add_sequencer #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 32,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout
);

  localparam int BEATS = WIDTH / 8;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);
  localparam logic [IDW:0]   NREQ_EXT  = (IDW + 1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [IDW-1:0]   id_q;
  logic [BW-1:0]    beat;
  logic             carry;

  // ---------------------------------------------------------------------------
  // Round-robin grant: first valid requester at or after rr_ptr, circularly.
  // Scanning offsets from high to low lets the smallest offset win last.
  // ---------------------------------------------------------------------------
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   cand;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      // rr_ptr + k stays below 2*NUM_REQ, so one conditional subtract wraps it.
      cand = {1'b0, rr_ptr} + (IDW + 1)'(k);
      if (cand >= NREQ_EXT) begin
        cand = cand - NREQ_EXT;
      end
      if (req_valid[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand[IDW-1:0];
      end
    end
  end

  logic accept;
  assign accept = (state == S_IDLE) && gnt_vld && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  // Operand select for the granted requester.
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared adder slice: current byte of each operand plus the chained carry.
  // ---------------------------------------------------------------------------
  logic [BW+2:0]    byte_lsb;
  logic [7:0]       add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] res_full;

  assign byte_lsb = {beat, 3'b000};

  add_8_1 u_add (
    .add1 (a_q[byte_lsb +: 8]),
    .add2 (b_q[byte_lsb +: 8]),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Result with this cycle's byte merged in, so the final beat can publish
  // the complete sum in the same edge that writes its last byte.
  always_comb begin
    res_full = res_q;
    res_full[byte_lsb +: 8] = add_sum;
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      id_q      <= '0;
      beat      <= '0;
      carry     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            carry  <= sel_cin;
            id_q   <= gnt_id;
            beat   <= '0;
            rr_ptr <= (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
            state  <= S_RUN;
          end
        end

        S_RUN: begin
          res_q <= res_full;
          carry <= add_cout;
          beat  <= beat + BW'(1);
          if (beat == LAST_BEAT) begin
            rsp_sum   <= res_full;
            rsp_cout  <= add_cout;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_add_sequencer.sv
// Purpose: randomized and directed checks of cla_add_sequencer against an arithmetic reference model.
// Latency: expects rsp_valid exactly BEATS+1 cycles after each accept.
// Backpressure: drives rsp_ready gaps and long stalls; checks response hold and req_ready gating.
module tb_cla_add_sequencer;

  localparam int NR  = 4;
  localparam int W   = 32;
  localparam int IDW = 2;
  localparam int LAT = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_a;
  logic [NR*W-1:0]   req_b;
  logic [NR-1:0]     req_cin;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;

  always #5 clk = ~clk;

  cla_add_sequencer #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  // Requester-side intent
  logic [W-1:0]  ra [NR];
  logic [W-1:0]  rb [NR];
  logic [NR-1:0] rv;
  logic [NR-1:0] rc;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NR; i++) begin
      req_a[i*W +: W] = ra[i];
      req_b[i*W +: W] = rb[i];
    end
  end
  assign req_valid = rv;
  assign req_cin   = rc;

  // Reference model state
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          busy  = 1'b0;
  int          acc_cyc;
  logic [W:0]  exp_res;
  int          exp_id;
  int          rr    = 0;
  int          ops   = 0;
  int          nrsp  = 0;
  int          waitc [NR];
  bit          after_rst = 1'b0;
  int          grants [$];
  int          accs [$];
  int          hs_cycs [$];
  logic [W-1:0] last_sum;
  logic         last_cout;
  int           last_id;

  // Stimulus modes
  bit auto_mode  = 1'b0;
  bit hold_all   = 1'b0;
  int stall_left = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic new_req(input int i);
    rv[i]    = 1'b1;
    ra[i]    = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
    rb[i]    = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
    rc[i]    = 1'($urandom_range(0, 1));
    waitc[i] = 0;
  endtask

  task automatic drive(input int g);
    if (g >= 0) begin
      if (hold_all) new_req(g);
      else          rv[g] = 1'b0;
    end
    rst = 1'b0;
    if (stall_left > 0) begin
      rsp_ready = 1'b0;
      if (rsp_valid) stall_left--;
    end else if (auto_mode) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      rsp_ready = 1'b1;
    end
    if (auto_mode) begin
      for (int i = 0; i < NR; i++) begin
        if (i != g) begin
          if (!rv[i]) begin
            if ($urandom_range(0, 2) == 0) new_req(i);
          end else if ($urandom_range(0, 49) == 0) begin
            rv[i]    = 1'b0;
            waitc[i] = 0;
          end
        end
      end
    end
  endtask

  // One clock: check at the falling edge, update the model, drive after the rising edge.
  task automatic step_cycle();
    logic [NR-1:0] er;
    int g;
    bit rst_now;
    @(negedge clk);
    cyc++;
    er = '0;
    g  = -1;
    if (!busy && !rst) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && rv[(rr + k) % NR]) g = (rr + k) % NR;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);

    if (busy && cyc >= acc_cyc + LAT) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_sum", rsp_sum, exp_res[W-1:0]);
      chk("rsp_cout", rsp_cout, exp_res[W]);
      chk("rsp_id", rsp_id, exp_id);
      if (rsp_ready) begin
        busy      = 1'b0;
        last_sum  = rsp_sum;
        last_cout = rsp_cout;
        last_id   = rsp_id;
        nrsp++;
        hs_cycs.push_back(cyc);
      end
    end else begin
      chk("rsp_valid", rsp_valid, 0);
    end

    if (after_rst) begin
      chk("rst_sum", rsp_sum, 0);
      chk("rst_cout", rsp_cout, 0);
      chk("rst_id", rsp_id, 0);
      after_rst = 1'b0;
    end

    if (g >= 0) begin
      busy    = 1'b1;
      acc_cyc = cyc;
      exp_res = {1'b0, ra[g]} + {1'b0, rb[g]} + (W + 1)'(rc[g]);
      exp_id  = g;
      rr      = (g + 1) % NR;
      chk("fair_wait", waitc[g] < NR, 1);
      waitc[g] = 0;
      for (int j = 0; j < NR; j++) if (j != g && rv[j]) waitc[j]++;
      grants.push_back(g);
      accs.push_back(cyc);
      ops++;
    end

    rst_now = rst;
    @(posedge clk);
    #1;
    if (rst_now) begin
      busy      = 1'b0;
      rr        = 0;
      after_rst = 1'b1;
    end
    drive(g);
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    do begin
      step_cycle();
      n++;
    end while ((busy || rv != '0) && n < maxc);
    chk("idle_reached", busy || (rv != '0), 0);
  endtask

  task automatic op_check(input string tag, input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W-1:0] es, input logic ec);
    int n0 = nrsp;
    rv[id] = 1'b1;
    ra[id] = a;
    rb[id] = b;
    rc[id] = c;
    wait_idle(40);
    chk({tag, "_count"}, nrsp - n0, 1);
    chk({tag, "_sum"}, last_sum, es);
    chk({tag, "_cout"}, last_cout, ec);
    chk({tag, "_id"}, last_id, id);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, a0, o0, n;
    rst       = 1'b1;
    rsp_ready = 1'b1;
    rv        = '0;
    rc        = '0;
    for (int i = 0; i < NR; i++) begin
      ra[i]    = '0;
      rb[i]    = '0;
      waitc[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    after_rst = 1'b1;

    // Directed arithmetic cases
    op_check("add_ff_1", 0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    op_check("ripple",   2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
    op_check("msb",      3, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);

    // Backpressure: response held 10 cycles while another requester waits
    n0 = nrsp;
    a0 = accs.size();
    rv[3] = 1'b1; ra[3] = 32'h1234_5678; rb[3] = 32'h9ABC_DEF0; rc[3] = 1'b0;
    stall_left = 10;
    rsp_ready  = 1'b0;
    step_cycle();
    rv[1] = 1'b1; ra[1] = 32'h0000_0010; rb[1] = 32'h0000_0020; rc[1] = 1'b1;
    wait_idle(80);
    chk("bp_count", nrsp - n0, 2);
    if (nrsp - n0 == 2 && accs.size() - a0 == 2) begin
      chk("bp_hold", hs_cycs[n0] - accs[a0], LAT + 10);
      chk("bp_reaccept", accs[a0+1] - hs_cycs[n0], 1);
    end
    chk("bp_last_sum", last_sum, 32'h0000_0031);

    // Reset two cycles after an accept drops the operation
    n0 = nrsp;
    rv[0] = 1'b1; ra[0] = 32'h0F0F_0F0F; rb[0] = 32'h0101_0101; rc[0] = 1'b1;
    step_cycle();
    step_cycle();
    rst   = 1'b1;
    rv[1] = 1'b1; ra[1] = 32'h1111_1111; rb[1] = 32'h2222_2222; rc[1] = 1'b0;
    step_cycle();
    wait_idle(40);
    chk("rst_resp_count", nrsp - n0, 1);
    chk("rst_new_id", last_id, 1);
    chk("rst_new_sum", last_sum, 32'h3333_3333);

    // Round robin with everyone requesting, starting from a fresh reset
    hold_all = 1'b1;
    for (int i = 0; i < NR; i++) new_req(i);
    rst = 1'b1;
    step_cycle();
    a0 = accs.size();
    n  = 0;
    while (accs.size() < a0 + 6 && n < 100) begin
      step_cycle();
      n++;
    end
    hold_all = 1'b0;
    rv = '0;
    wait_idle(20);
    chk("rr_count", accs.size() - a0 >= 6, 1);
    if (accs.size() - a0 >= 6) begin
      for (int k = 0; k < 6; k++) chk("rr_order", grants[a0+k], k % NR);
      for (int k = 1; k < 6; k++) chk("rr_gap", accs[a0+k] - accs[a0+k-1], LAT + 1);
    end

    // Randomized traffic
    o0 = ops;
    auto_mode = 1'b1;
    n = 0;
    while (ops < o0 + 2000 && n < 40000) begin
      step_cycle();
      n++;
    end
    auto_mode = 1'b0;
    rv = '0;
    wait_idle(60);
    chk("rand_ops", ops - o0 >= 2000, 1);
    // Every accepted operation answered except the one dropped by reset
    chk("rsp_total", nrsp, ops - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
